// File: rtl/strobe_gen_multi.sv
// -----------------------------------------------------------------------------
// strobe_gen_multi
//
// Synchronises a free-running reference clock (nominally 32,768 Hz) into the
// i_clk domain and advances a shared prescaler counter on every synchronised
// refclk rising edge. Each channel k emits a one-cycle strobe every 2^e
// reference edges, with e = min(i_exp[k], CNT_W) chosen at run time.
//
// Parameters:
//   NUM_CH      number of strobe channels (1..16)
//   CNT_W       prescaler counter width; largest usable exponent
//   EXP_W       width of each per-channel exponent field (2^EXP_W > CNT_W)
//   SYNC_STAGES flops in the refclk synchroniser (>= 2)
//
// Ports:
//   i_clk         system clock (faster than 2x refclk)
//   i_reset       synchronous, active-high reset
//   i_refclk      asynchronous reference clock
//   i_exp         per-channel exponent, channel k at [k*EXP_W +: EXP_W]
//   i_ch_en       per-channel strobe enable (sampled on rise cycles)
//   i_sync        single-cycle pulse; clears the prescaler, eats a coincident rise
//   o_stb         per-channel one-cycle strobes
//   o_refclk_stb  one-cycle pulse per synchronised refclk rising edge
//   o_count       registered prescaler value (only with STB_GEN_COUNT_OUT_EN)
//
// Optional feature macro: STB_GEN_COUNT_OUT_EN adds the o_count output.
// -----------------------------------------------------------------------------
module strobe_gen_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 15,
  parameter int EXP_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_refclk,
  input  logic [NUM_CH*EXP_W-1:0] i_exp,
  input  logic [NUM_CH-1:0]       i_ch_en,
  input  logic                    i_sync,
  output logic [NUM_CH-1:0]       o_stb,
  output logic                    o_refclk_stb
`ifdef STB_GEN_COUNT_OUT_EN
  ,
  output logic [CNT_W-1:0]        o_count
`endif
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("strobe_gen_multi: SYNC_STAGES must be at least 2");
  end
  if ((1 << EXP_W) <= CNT_W) begin : g_bad_exp
    $error("strobe_gen_multi: EXP_W too narrow to encode CNT_W");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_next;
  logic [NUM_CH-1:0]      hit;

  // True when the low e bits of n are all zero. Exponents above CNT_W
  // saturate on their own: the loop only ever inspects the CNT_W real bits,
  // so any e >= CNT_W means "whole counter is zero", i.e. the wrap point.
  function automatic logic low_bits_zero(input logic [CNT_W-1:0] n,
                                         input logic [EXP_W-1:0] e);
    logic z;
    z = 1'b1;
    for (int b = 0; b < CNT_W; b++) begin
      if ((b < int'(e)) && n[b]) z = 1'b0;
    end
    return z;
  endfunction

  assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign cnt_next = cnt_q + CNT_W'(1);

  // Strobe decision looks at the value the counter is about to take, so a
  // strobe lands in the same cycle the counter reaches a multiple of 2^e.
  always_comb begin
    // NOTE: assign a default before the loop so every path drives hit and
    // no latch is inferred.
    hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hit[k] = low_bits_zero(cnt_next, i_exp[k*EXP_W +: EXP_W]);
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q       <= '0;
      hist_q       <= 1'b0;
      cnt_q        <= '0;
      o_stb        <= '0;
      o_refclk_stb <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], i_refclk};
      hist_q       <= sync_q[SYNC_STAGES-1];
      o_refclk_stb <= rise;
      if (i_sync) begin
        // A rise coincident with sync is consumed: no count, no strobe.
        cnt_q <= '0;
        o_stb <= '0;
      end else if (rise) begin
        cnt_q <= cnt_next;
        o_stb <= i_ch_en & hit;
      end else begin
        o_stb <= '0;
      end
    end
  end

`ifdef STB_GEN_COUNT_OUT_EN
  assign o_count = cnt_q;
`endif

endmodule

// File: tb/tb_strobe_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_strobe_gen_multi
//
// Randomised refclk, enables, syncs and exponents against a behavioural model
// that tracks the refclk samples seen by the design and counts rises as plain
// integers. A period monitor additionally pins strobe spacing to literal
// per-configuration periods. A narrower counter (CNT_W=10) keeps wrap-around
// and saturation reachable in a short run.
// -----------------------------------------------------------------------------
module tb_strobe_gen_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 10;
  localparam int EXP_W  = 4;
  localparam int S      = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    refclk = 1'b0;
  logic [NUM_CH*EXP_W-1:0] exp_bus = '0;
  logic [NUM_CH-1:0]       en = '0;
  logic                    sync = 1'b0;
  logic [NUM_CH-1:0]       stb;
  logic                    rstb;
`ifdef STB_GEN_COUNT_OUT_EN
  logic [CNT_W-1:0]        count;
`endif

  strobe_gen_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .EXP_W(EXP_W), .SYNC_STAGES(S)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_refclk     (refclk),
    .i_exp        (exp_bus),
    .i_ch_en      (en),
    .i_sync       (sync),
    .o_stb        (stb),
    .o_refclk_stb (rstb)
`ifdef STB_GEN_COUNT_OUT_EN
    ,
    .o_count      (count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // smp[j] = refclk value the design sampled j+1 edges ago (0 once reset).
  logic [S:0]        smp = '0;
  int                m_cnt = 0;
  logic [NUM_CH-1:0] exp_stb = '0;
  logic              exp_rstb = 1'b0;
  bit                valid = 0;
  bit                ev_clear = 0;
  bit                m_rise;
  int                n_val;
  int                e_val;
  logic              rise_pending;

  assign rise_pending = smp[S-1] & ~smp[S];

  // Period monitor state
  int rc   [NUM_CH];
  bit seen [NUM_CH];
  bit gap  [NUM_CH];
  int per  [NUM_CH];

  initial forever begin
    @(posedge clk);
    #1;
    m_rise = smp[S-1] && !smp[S];
    if (rst) begin
      m_cnt    = 0;
      exp_stb  = '0;
      exp_rstb = 1'b0;
      smp      = '0;
      valid    = 1;
      ev_clear = 1;
    end else begin
      exp_rstb = m_rise;
      ev_clear = sync;
      if (sync) begin
        m_cnt   = 0;
        exp_stb = '0;
      end else if (m_rise) begin
        n_val = (m_cnt + 1) % (1 << CNT_W);
        for (int k = 0; k < NUM_CH; k++) begin
          e_val = int'(exp_bus[k*EXP_W +: EXP_W]);
          if (e_val > CNT_W) e_val = CNT_W;
          exp_stb[k] = en[k] && ((n_val % (1 << e_val)) == 0);
        end
        m_cnt = n_val;
      end else begin
        exp_stb = '0;
      end
      smp = {smp[S-1:0], refclk};
    end

    if (valid) begin
      check("stb", 64'(stb), 64'(exp_stb));
      check("refclk_stb", 64'(rstb), 64'(exp_rstb));
`ifdef STB_GEN_COUNT_OUT_EN
      check("count", 64'(count), 64'(m_cnt));
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        if (rstb === 1'b1) rc[k]++;
        if (stb[k] === 1'b1) begin
          if (seen[k]) begin
            if (gap[k]) check($sformatf("period_align_ch%0d", k), 64'(rc[k] % per[k]), 64'd0);
            else        check($sformatf("period_ch%0d", k), 64'(rc[k]), 64'(per[k]));
          end
          rc[k]   = 0;
          seen[k] = 1;
          gap[k]  = 0;
        end
        if (ev_clear) begin
          rc[k]   = 0;
          seen[k] = 1;
          gap[k]  = 0;
        end
        if (!en[k]) gap[k] = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit auto_ref = 0;
  int hold = 0;

  task automatic tick();
    @(negedge clk);
    if (auto_ref) begin
      if (hold == 0) begin
        refclk = ~refclk;
        hold   = $urandom_range(0, 3);
      end else begin
        hold--;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input logic [NUM_CH*EXP_W-1:0] e,
                         input int p0, input int p1, input int p2, input int p3);
    exp_bus = e;
    per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
    for (int k = 0; k < NUM_CH; k++) seen[k] = 0;
  endtask

  int  lat;
  bit  found;
  logic [NUM_CH*EXP_W-1:0] rnd_exp;
  int  rp [NUM_CH];

  initial begin
    for (int k = 0; k < NUM_CH; k++) begin
      rc[k] = 0; seen[k] = 0; gap[k] = 0; per[k] = 1;
    end
    en = '1;
    set_cfg({4'd10, 4'd7, 4'd4, 4'd0}, 1, 16, 128, 1024);

    // Reset for two cycles with refclk low.
    rst = 1'b1;
    run(2);
    check("reset_stb", 64'(stb), 64'd0);
    check("reset_refclk_stb", 64'(rstb), 64'd0);
    rst = 1'b0;
    run(4);

    // First rise latency: refclk goes high just before an edge; the pulse
    // must appear after SYNC_STAGES+1 edges.
    refclk = 1'b1;
    found  = 0;
    lat    = 0;
    for (int i = 1; i <= S + 2 && !found; i++) begin
      tick();
      if (rstb === 1'b1) begin
        found = 1;
        lat   = i;
      end
    end
    check("first_rise_seen", 64'(found), 64'd1);
    check("first_rise_latency", 64'(lat), 64'(S + 1));

    // Phase A: every exponent class, all enabled, random refclk.
    auto_ref = 1;
    run(12000);

    // Phase B: e=15 saturates to CNT_W; ch2 disabled for a long stretch.
    set_cfg({4'd4, 4'd4, 4'd15, 4'd3}, 8, 1024, 16, 16);
    run(2000);
    en[2] = 1'b0;
    run(3000);
    en[2] = 1'b1;
    run(9000);

    // Plain sync pulse.
    set_cfg({4'd4, 4'd4, 4'd2, 4'd0}, 1, 4, 16, 16);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    run(300);

    // Sync coincident with a rise: rise consumed, no strobe.
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (rise_pending) found = 1;
      else tick();
    end
    check("sync_rise_found", 64'(found), 64'd1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_coinc_stb", 64'(stb), 64'd0);
    check("sync_coinc_refclk_stb", 64'(rstb), 64'd1);
    run(400);

    // Reset mid-count.
    rst = 1'b1;
    tick();
    check("midreset_stb", 64'(stb), 64'd0);
    check("midreset_refclk_stb", 64'(rstb), 64'd0);
`ifdef STB_GEN_COUNT_OUT_EN
    check("midreset_count", 64'(count), 64'd0);
`endif
    rst = 1'b0;
    run(400);

    // Random phase: enables, syncs and exponents all vary.
    for (int blk = 0; blk < 6; blk++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        rnd_exp[k*EXP_W +: EXP_W] = EXP_W'($urandom_range(0, 15));
        e_val = int'(rnd_exp[k*EXP_W +: EXP_W]);
        rp[k] = 1 << ((e_val > CNT_W) ? CNT_W : e_val);
      end
      set_cfg(rnd_exp, rp[0], rp[1], rp[2], rp[3]);
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 99) == 0) en = NUM_CH'($urandom);
        sync = ($urandom_range(0, 499) == 0);
        tick();
      end
      sync = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/strobe_gen_multi.md
Name: strobe_gen_multi

Overview:
Parametrised successor to the fixed four-output strobe generator. Synchronises a free-running reference clock (nominally 32,768 Hz) into the system clock domain and advances a shared prescaler counter on each reference rising edge. Each of NUM_CH channels emits a one-cycle i_clk strobe every 2^e reference edges, with e selected at run time. Adds a per-channel enable and a phase-sync clear. Sits between the refclk pad and the clock/time-set logic.

Parameters:
NUM_CH, 4, number of strobe channels (1..16)
CNT_W, 15, prescaler counter width; maximum exponent is CNT_W
EXP_W, 4, width of each per-channel exponent field; must satisfy 2^EXP_W > CNT_W
SYNC_STAGES, 2, flip-flop stages in the refclk synchroniser (min 2)

Ports:
i_clk  input  1  system clock; must run faster than 2x refclk
i_reset  input  1  synchronous, active-high reset
i_refclk  input  1  asynchronous reference clock
i_exp  input  NUM_CH*EXP_W  per-channel exponent e; channel k uses bits [k*EXP_W +: EXP_W]
i_ch_en  input  NUM_CH  per-channel strobe enable
i_sync  input  1  single-cycle pulse; clears the prescaler counter
o_stb  output  NUM_CH  per-channel one-cycle strobes
o_refclk_stb  output  1  one-cycle pulse on each synchronised refclk rising edge

Behaviour:
- One clock, i_clk; synchronous active-high reset i_reset. All state changes on the i_clk rising edge.
- Reset: synchroniser stages, edge-detect register, counter, o_stb and o_refclk_stb all cleared to 0.
- Synchroniser: SYNC_STAGES flops, then one history flop.
  - rise = (last sync stage == 1) && (history == 0).
  - The history flop resets to 0, so a refclk held high through reset produces one rise after reset deassertion. This behaviour is intended.
- o_refclk_stb is registered rise; latency 1 cycle after rise.
- Counter, CNT_W bits, unsigned:
  - If i_sync: cnt <= 0. i_sync has priority over rise.
  - Else if rise: cnt <= cnt + 1, wrapping 2^CNT_W-1 -> 0.
  - Else: hold.
- Strobe condition, evaluated on a cycle with rise && !i_sync. Let n = cnt + 1 (next value) and e = min(i_exp[k], CNT_W).
  - o_stb[k] <= i_ch_en[k] && (n[e-1:0] == 0).
  - e = 0 means every rise strobes.
  - e = CNT_W strobes only on counter wrap, i.e. every 2^CNT_W edges.
- On all other cycles, o_stb <= 0. Every strobe is exactly one i_clk cycle wide and lands in the same cycle as o_refclk_stb.
- i_sync cycle: cnt <= 0 and o_stb <= 0, even if rise is coincident; that rise is consumed.
  - After sync, the first strobe for exponent e occurs on the 2^e-th subsequent rise.
- i_exp and i_ch_en are sampled only on rise cycles.
  - A change takes effect at the next rise. There is no stretched or partial strobe.
  - Disabling a channel does not affect the counter or other channels.
- Exponent values above CNT_W saturate to CNT_W.
- Reset mid-operation clears everything within one cycle; the counter restarts at 0.

Optional Feature:
Macro STB_GEN_COUNT_OUT_EN.
- Defined: adds output port o_count (CNT_W bits) equal to the registered counter value, for time-of-day sub-second readout.
- Undefined: port absent; no other behaviour changes.

Test Plan:
- Reset, with i_clk 100 ns and refclk 1003 ns: hold i_reset for 2 cycles -> o_stb=0, o_refclk_stb=0; first o_refclk_stb within SYNC_STAGES+2 cycles of the first refclk rise.
- Exponents {15, 14, 12, 4}, all enabled:
  - After a first strobe, count o_refclk_stb pulses up to the next strobe -> exactly 32768, 16384, 4096 and 16 respectively.
  - Each strobe is high 1 cycle, low the next.
- e=0 on ch0 -> o_stb[0] coincides with every o_refclk_stb. e=15 versus e=16 on ch1 (EXP_W=5 build) -> identical strobe timing, confirming saturation.
- i_ch_en[2]=0 for 10000 refclk edges with e=4 -> no o_stb[2] pulses. Other channels keep their periods. On re-enable, the next o_stb[2] stays aligned to a counter multiple of 16.
- Pulse i_sync, then pulse i_sync coincident with a rise (e=4) -> no strobe that cycle; next o_stb[3] after exactly 16 rises.
- Assert i_reset mid-count -> outputs 0 the next cycle; after release, the e=4 strobe arrives after exactly 16 rises. With STB_GEN_COUNT_OUT_EN, o_count reads 0 after reset and 16 at that strobe's cycle+1.
